// File: rtl/sort_pkg.sv
// Shared constants, types and helpers for the sort count-accumulation stage.
// Widths derive from the key range and the bank count.
package sort_pkg;

  localparam int SORT_FUC_MAX_NUM         = 256;
  localparam int SORT_FUC_BK_NUM          = 4;
  localparam int SORT_FUC_CNT_W           = 8;
  localparam int SORT_FUC_CNT_MEM_DEPTH   = SORT_FUC_MAX_NUM / SORT_FUC_BK_NUM;
  localparam int SORT_FUC_CNT_MEM_DEPTH_W = $clog2(SORT_FUC_CNT_MEM_DEPTH);
  localparam int SORT_FUC_BK_DEPTH_W      = $clog2(SORT_FUC_BK_NUM);
  localparam int SORT_FUC_WORD_W          = SORT_FUC_BK_NUM * SORT_FUC_CNT_W;

  typedef logic [SORT_FUC_CNT_W-1:0]           cnt_t;
  typedef logic [SORT_FUC_CNT_MEM_DEPTH_W-1:0] addr_t;
  typedef logic [SORT_FUC_BK_DEPTH_W-1:0]      bank_t;
  typedef logic [SORT_FUC_WORD_W-1:0]          word_t;

  typedef enum logic {
    ST_CLR = 1'b0,
    ST_RUN = 1'b1
  } cnt_state_e;

  function automatic logic cnt_is_sat(input cnt_t c);
    return c == '1;
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t c);
    return cnt_is_sat(c) ? c : c + cnt_t'(1);
  endfunction

endpackage

// File: rtl/sort_cnt_acc_if.sv
// Bundle of the count stage's request, clear, read and status signals.
// slave is the count stage itself; master is the surrounding logic.
interface sort_cnt_acc_if;
  import sort_pkg::*;

  logic  agu2cnt_vld_i;
  addr_t agu2cnt_addr_i;
  bank_t agu2cnt_bankid_i;
  logic  cnt_rdy_o;
  logic  cnt_clr_i;
  logic  cnt_clr_done_o;
  logic  cnt_rd_vld_i;
  addr_t cnt_rd_addr_i;
  logic  cnt_rd_vld_o;
  word_t cnt_rd_data_o;
  logic  cnt_ovf_o;

  modport slave (
    input  agu2cnt_vld_i, agu2cnt_addr_i, agu2cnt_bankid_i,
    input  cnt_clr_i, cnt_rd_vld_i, cnt_rd_addr_i,
    output cnt_rdy_o, cnt_clr_done_o, cnt_rd_vld_o, cnt_rd_data_o, cnt_ovf_o
  );

  modport master (
    output agu2cnt_vld_i, agu2cnt_addr_i, agu2cnt_bankid_i,
    output cnt_clr_i, cnt_rd_vld_i, cnt_rd_addr_i,
    input  cnt_rdy_o, cnt_clr_done_o, cnt_rd_vld_o, cnt_rd_data_o, cnt_ovf_o
  );

endinterface

// File: rtl/sort_cnt_bank_mem.sv
// Banked counter array: one register array per bank, a shared write address
// with per-bank enables, and two asynchronous whole-entry read ports.
module sort_cnt_bank_mem
  import sort_pkg::*;
(
  input  logic                       clk_i,
  input  logic [SORT_FUC_BK_NUM-1:0] we_i,
  input  addr_t                      waddr_i,
  input  word_t                      wdata_i,
  input  addr_t                      ra_addr_i,
  output word_t                      ra_data_o,
  input  addr_t                      rb_addr_i,
  output word_t                      rb_data_o
);

  for (genvar b = 0; b < SORT_FUC_BK_NUM; b++) begin : g_bank
    cnt_t mem_q [SORT_FUC_CNT_MEM_DEPTH];

    // NOTE: the array has no reset; the controller's clear sweep zeroes it,
    // which keeps it mappable to plain storage without a reset tree.
    always_ff @(posedge clk_i) begin
      if (we_i[b]) begin
        mem_q[waddr_i] <= wdata_i[b*SORT_FUC_CNT_W +: SORT_FUC_CNT_W];
      end
    end

    assign ra_data_o[b*SORT_FUC_CNT_W +: SORT_FUC_CNT_W] = mem_q[ra_addr_i];
    assign rb_data_o[b*SORT_FUC_CNT_W +: SORT_FUC_CNT_W] = mem_q[rb_addr_i];
  end

endmodule

// File: rtl/sort_cnt_acc.sv
// Count-accumulation stage: clear sequencer, 2-stage saturating increment
// pipeline over the banked counter array, and a registered word read port.
module sort_cnt_acc
  import sort_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  sort_cnt_acc_if.slave  bus
);

  cnt_state_e state_q, state_d;
  addr_t      clr_ptr_q, clr_ptr_d;
  logic       s1_vld_q, s1_vld_d;
  addr_t      s1_addr_q, s1_addr_d;
  bank_t      s1_bank_q, s1_bank_d;
  logic       rd_vld_q, rd_vld_d;
  word_t      rd_data_q, rd_data_d;
  logic       ovf_q, ovf_d;

  logic                       rdy, done, accept, s1_wr;
  logic [SORT_FUC_BK_NUM-1:0] mem_we;
  addr_t                      mem_waddr;
  word_t                      mem_wdata, s1_word, rd_word, rd_fwd;
  cnt_t                       s1_cnt, s1_next;

  sort_cnt_bank_mem u_mem (
    .clk_i     (clk_i),
    .we_i      (mem_we),
    .waddr_i   (mem_waddr),
    .wdata_i   (mem_wdata),
    .ra_addr_i (s1_addr_q),
    .ra_data_o (s1_word),
    .rb_addr_i (bus.cnt_rd_addr_i),
    .rb_data_o (rd_word)
  );

  // S1 write-back lands on the same edge that advances the next key into S1,
  // so the async read of a repeated key already sees the updated count.
  assign s1_cnt  = s1_word[s1_bank_q*SORT_FUC_CNT_W +: SORT_FUC_CNT_W];
  assign s1_next = sat_inc(s1_cnt);
  assign s1_wr   = s1_vld_q && !bus.cnt_clr_i;
  assign accept  = bus.agu2cnt_vld_i && rdy;

  // NOTE: every signal gets a default before the case statement so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ovf_d     = ovf_q;
    rdy       = 1'b0;
    done      = 1'b0;
    mem_we    = '0;
    mem_waddr = s1_addr_q;
    mem_wdata = {SORT_FUC_BK_NUM{s1_next}};

    unique case (state_q)
      ST_CLR: begin
        mem_we    = '1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        if (bus.cnt_clr_i) begin
          clr_ptr_d = '0;
        end else if (clr_ptr_q == addr_t'(SORT_FUC_CNT_MEM_DEPTH - 1)) begin
          state_d = ST_RUN;
          done    = 1'b1;
        end else begin
          clr_ptr_d = clr_ptr_q + addr_t'(1);
        end
      end
      ST_RUN: begin
        rdy = !bus.cnt_clr_i;
        if (s1_wr) begin
          mem_we[s1_bank_q] = 1'b1;
          if (cnt_is_sat(s1_cnt)) ovf_d = 1'b1;
        end
        if (bus.cnt_clr_i) begin
          state_d   = ST_CLR;
          clr_ptr_d = '0;
        end
      end
      default: state_d = ST_CLR;
    endcase

    if (bus.cnt_clr_i) ovf_d = 1'b0;
  end

  // Read result merges the S1 write retiring on the same edge as the request.
  always_comb begin
    rd_fwd = rd_word;
    if (s1_wr && (s1_addr_q == bus.cnt_rd_addr_i)) begin
      rd_fwd[s1_bank_q*SORT_FUC_CNT_W +: SORT_FUC_CNT_W] = s1_next;
    end

    rd_vld_d = bus.cnt_rd_vld_i;
    rd_data_d = rd_data_q;
    if (bus.cnt_rd_vld_i) begin
      rd_data_d = (state_q == ST_CLR) ? '0 : rd_fwd;
    end

    s1_vld_d  = accept;
    s1_addr_d = accept ? bus.agu2cnt_addr_i   : s1_addr_q;
    s1_bank_d = accept ? bus.agu2cnt_bankid_i : s1_bank_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its _d value from before the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_CLR;
      clr_ptr_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      s1_bank_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      s1_vld_q  <= s1_vld_d;
      s1_addr_q <= s1_addr_d;
      s1_bank_q <= s1_bank_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.cnt_rdy_o      = rdy;
  assign bus.cnt_clr_done_o = done;
  assign bus.cnt_rd_vld_o   = rd_vld_q;
  assign bus.cnt_rd_data_o  = rd_data_q;
  assign bus.cnt_ovf_o      = ovf_q;

endmodule

// File: tb/tb_sort_cnt_acc.sv
// Self-checking bench for sort_cnt_acc: table vectors, hand-written corner
// sequences, and random traffic against a per-counter array model.
module tb_sort_cnt_acc;
  import sort_pkg::*;

  localparam int DEPTH = SORT_FUC_CNT_MEM_DEPTH;
  localparam int BK    = SORT_FUC_BK_NUM;
  localparam int CW    = SORT_FUC_CNT_W;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sort_cnt_acc_if bus ();
  sort_cnt_acc dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one integer per counter plus a sticky overflow flag.
  int model_cnt [DEPTH][BK];
  bit model_ovf;

  typedef struct {
    int    addr;
    int    bank;
    int    reps;
    int    rd_addr;
    word_t exp_word;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.agu2cnt_vld_i    = 1'b0;
    bus.agu2cnt_addr_i   = '0;
    bus.agu2cnt_bankid_i = '0;
    bus.cnt_clr_i        = 1'b0;
    bus.cnt_rd_vld_i     = 1'b0;
    bus.cnt_rd_addr_i    = '0;
  endtask

  function automatic word_t model_word(input int a);
    word_t w;
    w = '0;
    for (int b = 0; b < BK; b++) w[b*CW +: CW] = cnt_t'(model_cnt[a][b]);
    return w;
  endfunction

  task automatic model_key(input int a, input int b);
    if (model_cnt[a][b] == CMAX) model_ovf = 1'b1;
    else model_cnt[a][b] = model_cnt[a][b] + 1;
  endtask

  task automatic model_clear();
    for (int a = 0; a < DEPTH; a++)
      for (int b = 0; b < BK; b++) model_cnt[a][b] = 0;
    model_ovf = 1'b0;
  endtask

  // Back-to-back keys; the stage is known to be in RUN with no clear pending.
  task automatic send(input int a, input int b, input int reps);
    for (int i = 0; i < reps; i++) begin
      bus.agu2cnt_vld_i    = 1'b1;
      bus.agu2cnt_addr_i   = addr_t'(a);
      bus.agu2cnt_bankid_i = bank_t'(b);
      tick();
      model_key(a, b);
    end
    bus.agu2cnt_vld_i = 1'b0;
  endtask

  task automatic read_word(input int a, output logic vld, output word_t data);
    bus.cnt_rd_vld_i  = 1'b1;
    bus.cnt_rd_addr_i = addr_t'(a);
    tick();
    vld  = bus.cnt_rd_vld_o;
    data = bus.cnt_rd_data_o;
    bus.cnt_rd_vld_i = 1'b0;
  endtask

  task automatic read_model(input string name, input int a);
    logic  vld;
    word_t data;
    word_t exp;
    exp = model_word(a);
    read_word(a, vld, data);
    check({name, "_vld"}, vld, 1'b1);
    check(name, data, exp);
  endtask

  // Caller is positioned on the first clear cycle (entry 0 being written).
  task automatic check_sweep(input string tag, input int rd_at, input int reclr_at,
                             input int exp_done);
    int done_cyc;
    int done_cnt;
    int rdy_cyc;
    done_cyc = 0;
    done_cnt = 0;
    rdy_cyc  = 0;
    for (int c = 1; c <= exp_done + 8; c++) begin
      if (c > 1) tick();
      if (c == 1) check({tag, "_ovf_cleared"}, bus.cnt_ovf_o, 1'b0);
      if (rd_at > 0 && c == rd_at + 1) begin
        check({tag, "_clr_rd_vld"}, bus.cnt_rd_vld_o, 1'b1);
        check({tag, "_clr_rd_data"}, bus.cnt_rd_data_o, '0);
      end
      if (bus.cnt_clr_done_o) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (bus.cnt_rdy_o && rdy_cyc == 0) rdy_cyc = c;
      bus.cnt_rd_vld_i  = (c == rd_at);
      bus.cnt_rd_addr_i = addr_t'(5);
      bus.cnt_clr_i     = (c == reclr_at);
    end
    idle_inputs();
    check({tag, "_done_cycle"}, done_cyc, exp_done);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_rdy_cycle"}, rdy_cyc, exp_done + 1);
  endtask

  task automatic random_traffic(input int n);
    logic  v, r;
    int    a, b, ra;
    word_t exp;
    for (int i = 0; i < n; i++) begin
      v  = ($urandom_range(0, 9) < 7);
      a  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH-1) : $urandom_range(0, 1);
      b  = $urandom_range(0, BK-1);
      r  = ($urandom_range(0, 9) < 3);
      ra = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH-1) : $urandom_range(0, 1);
      bus.agu2cnt_vld_i    = v;
      bus.agu2cnt_addr_i   = addr_t'(a);
      bus.agu2cnt_bankid_i = bank_t'(b);
      bus.cnt_rd_vld_i     = r;
      bus.cnt_rd_addr_i    = addr_t'(ra);
      exp = model_word(ra);
      if (i % 100 == 0) check("rand_rdy", bus.cnt_rdy_o, 1'b1);
      if (v) model_key(a, b);
      tick();
      check("rand_rd_vld", bus.cnt_rd_vld_o, r);
      if (r) check("rand_rd_data", bus.cnt_rd_data_o, exp);
    end
    idle_inputs();
    tick();
    tick();
    check("rand_ovf", bus.cnt_ovf_o, model_ovf);
  endtask

  initial begin
    logic  vld;
    word_t data;

    vecs[0] = '{5,  2, 3, 5,  32'h0003_0000};
    vecs[1] = '{10, 0, 1, 10, 32'h0000_0001};
    vecs[2] = '{63, 3, 7, 63, 32'h0700_0000};
    vecs[3] = '{5,  0, 2, 5,  32'h0003_0002};
    vecs[4] = '{0,  1, 4, 0,  32'h0000_0400};
    vecs[5] = '{5,  2, 1, 5,  32'h0004_0002};

    rst = 1'b1;
    idle_inputs();
    model_clear();
    tick();
    tick();
    check("rst_rdy", bus.cnt_rdy_o, 1'b0);
    check("rst_done", bus.cnt_clr_done_o, 1'b0);
    check("rst_rd_vld", bus.cnt_rd_vld_o, 1'b0);
    check("rst_rd_data", bus.cnt_rd_data_o, '0);
    check("rst_ovf", bus.cnt_ovf_o, 1'b0);
    rst = 1'b0;
    check_sweep("init", 0, 0, DEPTH);
    for (int a = 0; a < DEPTH; a++) read_model("init_zero", a);

    // Table vectors: keys back-to-back, then a read of the entry.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].addr, vecs[i].bank, vecs[i].reps);
      read_word(vecs[i].rd_addr, vld, data);
      check("vec_rd_vld", vld, 1'b1);
      check($sformatf("vec%0d_data", i), data, vecs[i].exp_word);
    end
    check("vec_no_ovf", bus.cnt_ovf_o, 1'b0);

    // Read in the accept cycle excludes the key; read one cycle later sees it.
    bus.agu2cnt_vld_i    = 1'b1;
    bus.agu2cnt_addr_i   = addr_t'(30);
    bus.agu2cnt_bankid_i = bank_t'(1);
    read_word(30, vld, data);
    bus.agu2cnt_vld_i = 1'b0;
    model_key(30, 1);
    check("fwd_same_cycle", data, 32'h0000_0000);
    read_word(30, vld, data);
    check("fwd_next_cycle", data, 32'h0000_0100);

    // Alternating banks of one entry, back-to-back.
    for (int i = 0; i < 20; i++) begin
      bus.agu2cnt_vld_i    = 1'b1;
      bus.agu2cnt_addr_i   = addr_t'(20);
      bus.agu2cnt_bankid_i = bank_t'((i % 2 == 0) ? 2 : 3);
      tick();
      model_key(20, (i % 2 == 0) ? 2 : 3);
    end
    bus.agu2cnt_vld_i = 1'b0;
    read_word(20, vld, data);
    check("alt_banks", data, 32'h0A0A_0000);

    random_traffic(1200);

    // Saturation: counter sticks at all-ones and overflow stays set.
    send(0, 0, 300);
    read_word(0, vld, data);
    check("sat_value", data[CW-1:0], CMAX);
    check("sat_model", data, model_word(0));
    tick();
    check("sat_ovf", bus.cnt_ovf_o, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    check("sat_ovf_sticky", bus.cnt_ovf_o, 1'b1);

    // Asynchronous reset while keys are streaming.
    bus.agu2cnt_vld_i    = 1'b1;
    bus.agu2cnt_addr_i   = addr_t'(2);
    bus.agu2cnt_bankid_i = bank_t'(2);
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_rdy", bus.cnt_rdy_o, 1'b0);
    check("arst_rd_vld", bus.cnt_rd_vld_o, 1'b0);
    check("arst_ovf", bus.cnt_ovf_o, 1'b0);
    idle_inputs();
    model_clear();
    tick();
    tick();
    rst = 1'b0;
    check_sweep("arst", 0, 0, DEPTH);
    send(0, 0, 2);
    read_word(0, vld, data);
    check("arst_recount", data, 32'h0000_0002);
    read_model("arst_entry2", 2);

    // Clear with a simultaneous request after loading counts and overflow.
    send(3, 1, 256);
    tick();
    check("preclr_ovf", bus.cnt_ovf_o, 1'b1);
    bus.cnt_clr_i        = 1'b1;
    bus.agu2cnt_vld_i    = 1'b1;
    bus.agu2cnt_addr_i   = addr_t'(40);
    bus.agu2cnt_bankid_i = bank_t'(0);
    #1;
    check("clr_blocks_rdy", bus.cnt_rdy_o, 1'b0);
    tick();
    idle_inputs();
    model_clear();
    check_sweep("clr", 10, 0, DEPTH);
    for (int a = 0; a < DEPTH; a++) read_model("clr_zero", a);

    // Clear reissued mid-sweep restarts from entry 0.
    send(7, 3, 3);
    bus.cnt_clr_i = 1'b1;
    tick();
    idle_inputs();
    model_clear();
    check_sweep("reclr", 0, 10, 10 + DEPTH);
    read_model("reclr_entry7", 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sort_cnt_acc.md
Name: sort_cnt_acc

Overview:
- Count-accumulation stage directly downstream of the address-generation stage.
- Consumes the count-path outputs (valid, entry address, bank id) and increments one counter per accepted key in a banked counter array: depth × bank counters.
- Provides a clear sequencer, a saturating/sticky-overflow policy and a word read port for the later prefix-sum/output stage.

Parameters:
- SORT_FUC_MAX_NUM, 256, key range (number of distinct keys).
- SORT_FUC_BK_NUM, 4, counter banks per entry (power of 2).
- SORT_FUC_CNT_W, 8, width of one counter.
- SORT_FUC_CNT_MEM_DEPTH, SORT_FUC_MAX_NUM/SORT_FUC_BK_NUM, entries.
- SORT_FUC_CNT_MEM_DEPTH_W, $clog2(SORT_FUC_CNT_MEM_DEPTH), entry address width.
- SORT_FUC_BK_DEPTH_W, $clog2(SORT_FUC_BK_NUM), bank id width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- agu2cnt_vld_i  in  1  increment request valid.
- agu2cnt_addr_i  in  SORT_FUC_CNT_MEM_DEPTH_W  entry address.
- agu2cnt_bankid_i  in  SORT_FUC_BK_DEPTH_W  bank within entry.
- cnt_rdy_o  out  1  stage accepts requests this cycle.
- cnt_clr_i  in  1  start full-array clear (pulse).
- cnt_clr_done_o  out  1  one-cycle pulse when clear completes.
- cnt_rd_vld_i  in  1  word read request.
- cnt_rd_addr_i  in  SORT_FUC_CNT_MEM_DEPTH_W  word read address.
- cnt_rd_vld_o  out  1  read data valid (1 cycle after request).
- cnt_rd_data_o  out  SORT_FUC_BK_NUM*SORT_FUC_CNT_W  all banks of entry; bank b at bits [b*CNT_W +: CNT_W].
- cnt_ovf_o  out  1  sticky: some counter saturated.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: FSM=CLR, clear pointer=0, cnt_rdy_o=0, cnt_clr_done_o=0, cnt_rd_vld_o=0, cnt_rd_data_o=0, cnt_ovf_o=0, pipeline valid=0. Array contents are not reset; they are cleared by the CLR sweep.
- FSM states: CLR, RUN.
  - CLR: one entry per cycle (all banks of entry ptr written 0), ptr 0..DEPTH-1. After writing DEPTH-1: go to RUN and pulse cnt_clr_done_o for one cycle. The clear therefore takes DEPTH cycles. cnt_ovf_o is cleared on entry to CLR.
  - RUN: cnt_rdy_o=1. A request is accepted when vld_i && rdy_o. Requests presented while rdy_o=0 are dropped; the upstream stage must hold them.
  - cnt_clr_i in RUN: go to CLR next cycle. cnt_rdy_o drops in that same cycle (combinational from cnt_clr_i), so no request is accepted. Any in-flight stage-1 write is discarded. cnt_clr_i in CLR restarts ptr at 0.
- Accumulation pipeline (2 stages, throughput 1/cycle):
  - S0 (accept cycle): register addr/bank.
  - S1: read counter, compute next = (cnt == all-ones) ? cnt : cnt+1, write back at end of S1. When cnt == all-ones, set cnt_ovf_o.
  - Forwarding: if the S1 request matches the previous S1 request's addr/bank and that write is still pending in the same cycle, use the forwarded value. Back-to-back identical keys must give +1 per key with no lost update.
  - Different banks of the same entry in consecutive cycles update independently.
- Read port:
  - cnt_rd_vld_o/cnt_rd_data_o are registered, 1-cycle latency, valid in RUN only. A request in CLR returns vld_o=1 with data=0.
  - Data includes every increment whose S1 write completed at or before the read-request cycle's edge. The write of an S1 stage occurring in the request cycle is forwarded into the read result.
  - Reads and accumulation proceed concurrently; there is no stall.
- Simultaneous cnt_clr_i and agu2cnt_vld_i: clear wins, request not accepted.
- Reset mid-operation: all state returns to reset values, and the FSM restarts the CLR sweep from entry 0.

Decomposition:
- Shared package sort_pkg:
  - SORT_FUC_* width constants and derived widths.
  - FSM state enum {CLR, RUN}.
  - Function for counter saturating increment.
- One sub-module, sort_cnt_bank_mem: register array per bank with one write port and two async read ports (S1 and read port).
- FSM, pipeline and forwarding stay in the top level.

Test Plan:
- Reset, then idle: cnt_rdy_o=0 for 64 cycles, cnt_clr_done_o pulses in cycle 64, cnt_rdy_o=1 the next cycle. Reading addr 0..63 returns 0.
- Keys addr=5/bank=2 sent 3 times back-to-back, then read addr 5 -> data bank2=3, other banks 0, no ovf.
- Alternating addr5/bank2 and addr5/bank3, 10 requests each back-to-back -> read addr 5 gives bank2=10, bank3=10.
- 300 requests to addr 0/bank 0 with CNT_W=8 -> counter saturates at 255, cnt_ovf_o=1 and stays set until the next clear.
- cnt_clr_i asserted with agu2cnt_vld_i in the same cycle, after counts were loaded -> request not accepted. Done pulse arrives 64 cycles later, all reads return 0, cnt_ovf_o=0.
- rst_i asserted mid-accumulation -> outputs go to reset values immediately (async). After release, the full CLR sweep runs and subsequent counts start from 0.
